// File: rtl/decoder_3to8.sv
// Registered 3-to-8 line decoder with G1/G2 dual enable (74x138 behaviour).
// Produces a one-cold, active-low select one clock after the code is sampled.
`timescale 1ns/1ps
module decoder_3to8 #(
  parameter int IN_W = 3,
  parameter logic [(2**IN_W)-1:0] OUT_RESET = {(2**IN_W){1'b1}}
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic [IN_W-1:0]        iData,
  input  logic [1:0]             iEna,
  output logic [(2**IN_W)-1:0]   oData,
  output logic                   oValid
);

  localparam int OUT_W = 2**IN_W;

  logic             en_s;
  logic [OUT_W-1:0] data_d;
  logic [OUT_W-1:0] data_q;
  logic             valid_d;
  logic             valid_q;

  // One-cold decode: only the bit whose index equals the code is driven low.
  function automatic logic [OUT_W-1:0] decode_one_cold(input logic [IN_W-1:0] code);
    logic [OUT_W-1:0] sel;
    sel = {OUT_W{1'b1}};
    for (int k = 0; k < OUT_W; k++) begin
      if (code == IN_W'(k)) begin
        sel[k] = 1'b0;
      end else begin
        sel[k] = 1'b1;
      end
    end
    return sel;
  endfunction

  // Next-state select and valid from the enable pair (G1 high, G2 low).
  always_comb begin
    en_s    = iEna[1] & ~iEna[0];
    data_d  = OUT_RESET;
    valid_d = 1'b0;
    if (en_s) begin
      data_d  = decode_one_cold(iData);
      valid_d = 1'b1;
    end else begin
      data_d  = OUT_RESET;
      valid_d = 1'b0;
    end
  end

  // Output register; reset clears the select immediately, without a clock.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      data_q  <= OUT_RESET;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign oData  = data_q;
  assign oValid = valid_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Table-driven bench for decoder_3to8: directed vectors with hand-computed
// selects, plus hand-written reset and mid-cycle sequences.
`timescale 1ns/1ps
module tb_decoder_3to8;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic [2:0] iData;
  logic [1:0] iEna;
  logic [7:0] oData;
  logic       oValid;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [2:0] d;
    logic [1:0] e;
    logic [7:0] exp_d;
    logic       exp_v;
  } vec_t;

  vec_t vecs[$];

  decoder_3to8 dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iData  (iData),
    .iEna   (iEna),
    .oData  (oData),
    .oValid (oValid)
  );

  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic void add(input string name, input logic [2:0] d, input logic [1:0] e,
                              input logic [7:0] exp_d, input logic exp_v);
    vec_t v;
    v.name = name; v.d = d; v.e = e; v.exp_d = exp_d; v.exp_v = exp_v;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] exp_d, input logic exp_v);
    n_vec++;
    if (oData !== exp_d || oValid !== exp_v) begin
      n_err++;
      $display("FAIL %s: got oData=%h oValid=%b, expected oData=%h oValid=%b",
               name, oData, oValid, exp_d, exp_v);
    end
  endtask

  task automatic check_one_cold(input string name);
    n_vec++;
    if ($countones(~oData) != 1) begin
      n_err++;
      $display("FAIL %s: got %0d low bits in oData=%h, expected 1", name, $countones(~oData), oData);
    end
  endtask

  initial begin
    // Disabled enable codes, each held for two edges.
    add("dis_00_a", 3'b110, 2'b00, 8'hFF, 1'b0);
    add("dis_00_b", 3'b110, 2'b00, 8'hFF, 1'b0);
    add("dis_11_a", 3'b110, 2'b11, 8'hFF, 1'b0);
    add("dis_11_b", 3'b110, 2'b11, 8'hFF, 1'b0);
    add("dis_01_a", 3'b110, 2'b01, 8'hFF, 1'b0);
    add("dis_01_b", 3'b110, 2'b01, 8'hFF, 1'b0);
    // Full sweep with enable active.
    add("sweep_0", 3'd0, 2'b10, 8'hFE, 1'b1);
    add("sweep_1", 3'd1, 2'b10, 8'hFD, 1'b1);
    add("sweep_2", 3'd2, 2'b10, 8'hFB, 1'b1);
    add("sweep_3", 3'd3, 2'b10, 8'hF7, 1'b1);
    add("sweep_4", 3'd4, 2'b10, 8'hEF, 1'b1);
    add("sweep_5", 3'd5, 2'b10, 8'hDF, 1'b1);
    add("sweep_6", 3'd6, 2'b10, 8'hBF, 1'b1);
    add("sweep_7", 3'd7, 2'b10, 8'h7F, 1'b1);
    // Enable drop and restore.
    add("drop_on",   3'b011, 2'b10, 8'hF7, 1'b1);
    add("drop_off",  3'b011, 2'b11, 8'hFF, 1'b0);
    add("drop_back", 3'b011, 2'b10, 8'hF7, 1'b1);
    // Back-to-back code changes.
    add("b2b_000", 3'b000, 2'b10, 8'hFE, 1'b1);
    add("b2b_111", 3'b111, 2'b10, 8'h7F, 1'b1);
    add("b2b_000b", 3'b000, 2'b10, 8'hFE, 1'b1);

    // Reset held with clock running and an enabled code on the inputs.
    iRst_n = 1'b0;
    iData  = 3'b110;
    iEna   = 2'b10;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("rst_held", 8'hFF, 1'b0);
    iRst_n = 1'b1;
    @(negedge iClk);
    check("rst_release", 8'hBF, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      iData = vecs[i].d;
      iEna  = vecs[i].e;
      @(negedge iClk);
      check(vecs[i].name, vecs[i].exp_d, vecs[i].exp_v);
      if (vecs[i].exp_v) begin
        check_one_cold({vecs[i].name, "_onecold"});
      end
    end

    // Asynchronous reset pulse between edges while 7F is showing.
    iData = 3'd7;
    iEna  = 2'b10;
    @(negedge iClk);
    check("pre_async", 8'h7F, 1'b1);
    #1 iRst_n = 1'b0;
    #1 check("async_rst", 8'hFF, 1'b0);
    #1 iRst_n = 1'b1;
    #1 check("async_release_noedge", 8'hFF, 1'b0);
    @(negedge iClk);
    check("async_recover", 8'h7F, 1'b1);

    // Input changes between edges must not reach the output.
    #1 iData = 3'd2;
    #1 check("mid_cycle_hold", 8'h7F, 1'b1);
    #1 iData = 3'd7;
    @(negedge iClk);
    check("mid_cycle_sampled", 8'h7F, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_3to8.md
Name: decoder_3to8

Overview:
- Registered 3-to-8 line decoder with dual enable, equivalent to a 74x138.
- Converts a 3-bit binary code into a one-cold, active-low 8-bit select vector.
- Used as a chip-select / row-select generator in synchronous logic.
- Output is registered on one clock with an asynchronous active-low reset, so downstream logic sees a clean, glitch-free select.

Parameters:
- IN_W, 3, width of the binary code input. Output width is 2**IN_W. All values in this spec assume the default.
- OUT_RESET, all ones (8'hFF at default), value oData takes during reset and while disabled (all outputs inactive).

Ports:
- iClk  input  1  single clock; all state updates on its rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iData  input  IN_W (3)  binary code to decode. Bit 2 = D2 (MSB), bit 0 = D0.
- iEna  input  2  enable pair. iEna[1] = G1, active-high. iEna[0] = G2, active-low.
- oData  output  2**IN_W (8)  decoded select, active-low, one-cold when enabled.
- oValid  output  1  high when the registered oData reflects an enabled decode.

Behaviour:
- Enable condition: en = iEna[1] & ~iEna[0]. Only iEna = 2'b10 enables the decoder. Values 2'b00, 2'b01 and 2'b11 disable it.
- Combinational next value when enabled:
  - bit k of next_oData = 0 if k == iData, else 1.
  - Exactly one bit is low.
- Combinational next value when disabled: next_oData = OUT_RESET (all ones), next_oValid = 0.
- Register update: on each rising iClk with iRst_n high, oData <= next_oData and oValid <= en.
- Latency: exactly 1 clock from sampled iData/iEna to oData/oValid. No other pipeline stages. Inputs are sampled only at the clock edge; input changes between edges have no effect on outputs.
- Reset:
  - iRst_n low forces oData = all ones and oValid = 0 immediately, without waiting for a clock edge.
  - Reset held low keeps the outputs there regardless of the clock.
  - Reset asserted mid-operation drops the active output line high at once.
  - Release of reset is synchronous in effect: the first decode appears on the first rising edge after iRst_n goes high.
- Enable toggling between cycles:
  - Disable → enable: decoded value appears one edge later.
  - Enable → disable: all ones appears one edge later.
- iData changing while enabled: the low bit moves to the new index on the next edge. No cycle with two low bits and no cycle with zero low bits in between.
- Output encoding: no X/Z on outputs after reset. Every input combination maps to a defined output.
- Width rules: 2**IN_W output bits, index k compared as an unsigned IN_W-bit value. No wrap-around or overflow cases exist.

Test Plan:
- Reset: assert iRst_n = 0 with the clock running and inputs 3'b110 / 2'b10 → oData = 8'hFF, oValid = 0. Deassert, one edge later → oData = 8'hBF, oValid = 1.
- Disabled enables: iData = 3'b110 with iEna = 2'b00, then 2'b11, then 2'b01, each held for at least 2 edges → oData = 8'hFF, oValid = 0 for all three.
- Full sweep: iEna = 2'b10, iData = 000..111, one code per cycle → oData one edge later = FE, FD, FB, F7, EF, DF, BF, 7F, with oValid = 1.
- Enable drop: iEna = 2'b10, iData = 3'b011 (oData = F7), then iEna → 2'b11 → next edge oData = FF, oValid = 0. Restore 2'b10 → next edge oData = F7.
- Asynchronous reset mid-operation: oData = 8'h7F. Pulse iRst_n low between clock edges → oData = FF and oValid = 0 before the next edge. After release → 7F returns on the following edge.
- Back-to-back code changes: iData = 000 → 111 → 000 on consecutive edges with enable high → oData = FE, 7F, FE. Every cycle has exactly one zero bit.
